// File: rtl/usb_tx_arbiter_if.sv
// Handshake and data bundle between the two requesters, the USB byte writer
// and the arbiter.
interface usb_tx_arbiter_if;
   logic       req0;
   logic [4:0] len0;
   logic [7:0] rdata0;
   logic       req1;
   logic [4:0] len1;
   logic [7:0] rdata1;
   logic [4:0] rd_addr;
   logic [1:0] grant;
   logic [1:0] done;
   logic [7:0] wr_data;
   logic       wr_new;
   logic       wr_done;
   logic       busy;
   logic       err;

   modport master (
      input  req0, len0, rdata0,
      input  req1, len1, rdata1,
      input  wr_done,
      output rd_addr, grant, done,
      output wr_data, wr_new,
      output busy, err
   );

   modport slave (
      output req0, len0, rdata0,
      output req1, len1, rdata1,
      output wr_done,
      input  rd_addr, grant, done,
      input  wr_data, wr_new,
      input  busy, err
   );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Round-robin framer sharing one USB byte writer between two requesters.
// Frame: SYNC, header {src,00,len}, payload, 8-bit sum of header+payload.
module usb_tx_arbiter #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 1000
) (
   input logic             clk,
   input logic             reset,
   usb_tx_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   typedef enum logic [1:0] {
      P_SYNC,
      P_HDR,
      P_PAY,
      P_SUM
   } phase_t;

   localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   phase_t      phase, phase_n;
   logic [1:0]  grant, grant_n;
   logic        src, src_n;
   logic        last, last_n;
   logic [4:0]  len_q, len_n;
   logic [4:0]  addr, addr_n;
   logic [7:0]  csum, csum_n;
   logic [15:0] cnt, cnt_n;
   logic [7:0]  byte_out;
   logic        sel;
   logic        done_c, err_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         phase <= P_SYNC;
         grant <= '0;
         src   <= 1'b0;
         last  <= 1'b1;
         len_q <= '0;
         addr  <= '0;
         csum  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         grant <= grant_n;
         src   <= src_n;
         last  <= last_n;
         len_q <= len_n;
         addr  <= addr_n;
         csum  <= csum_n;
         cnt   <= cnt_n;
      end
   end

   // Same byte is rebuilt in WAIT to fold it into the checksum.
   always_comb begin
      byte_out = SYNC_BYTE;
      unique case (phase)
         P_SYNC: byte_out = SYNC_BYTE;
         P_HDR:  byte_out = {src, 2'b00, len_q};
         P_PAY:  byte_out = src ? bus.rdata1 : bus.rdata0;
         P_SUM:  byte_out = csum;
      endcase
   end

   assign sel = (bus.req0 & bus.req1) ? ~last : bus.req1;

   always_comb begin
      state_n = state;
      phase_n = phase;
      grant_n = grant;
      src_n   = src;
      last_n  = last;
      len_n   = len_q;
      addr_n  = addr;
      csum_n  = csum;
      cnt_n   = cnt;
      done_c  = 1'b0;
      err_c   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.req0 | bus.req1) begin
               src_n   = sel;
               grant_n = sel ? 2'b10 : 2'b01;
               len_n   = sel ? bus.len1 : bus.len0;
               addr_n  = '0;
               csum_n  = '0;
               phase_n = P_SYNC;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_n   = '0;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            cnt_n = cnt + 16'd1;
            if (bus.wr_done) begin
               state_n = S_ISSUE;
               if (phase == P_HDR || phase == P_PAY)
                  csum_n = csum + byte_out;
               unique case (phase)
                  P_SYNC: phase_n = P_HDR;
                  P_HDR:  phase_n = (len_q == 5'd0) ? P_SUM : P_PAY;
                  P_PAY: begin
                     addr_n = addr + 5'd1;
                     if (addr == len_q - 5'd1)
                        phase_n = P_SUM;
                  end
                  P_SUM: begin
                     done_c  = 1'b1;
                     last_n  = src;
                     grant_n = '0;
                     state_n = S_IDLE;
                  end
               endcase
            end else if (cnt == TMAX) begin
               err_c   = 1'b1;
               last_n  = src;
               grant_n = '0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.wr_new  = (state == S_ISSUE);
   assign bus.wr_data = bus.wr_new ? byte_out : 8'h00;
   assign bus.busy    = (state != S_IDLE);
   assign bus.grant   = grant;
   assign bus.rd_addr = addr;
   assign bus.done    = done_c ? grant : 2'b00;
   assign bus.err     = err_c;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: expected bytes/events queued by the
// stimulus, popped by a negedge monitor.
module tb_usb_tx_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   usb_tx_arbiter_if bus ();

   usb_tx_arbiter #(
      .SYNC_BYTE(8'hA5),
      .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct packed {
      logic [7:0] b;
      logic [1:0] g;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] ev_q[$];
   logic [7:0] mem0[32];
   logic [7:0] mem1[32];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         new_cyc = 0;
   int         err_cyc = 0;
   int         ack_dly = 1;
   bit         ack_en = 1'b1;

   assign bus.rdata0 = mem0[bus.rd_addr];
   assign bus.rdata1 = mem1[bus.rd_addr];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic pb(logic [7:0] b, logic [1:0] g);
      exp_t e;
      e.b = b;
      e.g = g;
      exp_q.push_back(e);
   endtask

   task automatic wait_ev(string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.done == 2'b00 && !bus.err && k < 200);
      if (bus.done == 2'b00 && !bus.err) begin
         tests++;
         fails++;
         $display("FAIL %s: no done/err within 200 cycles", nm);
      end
   endtask

   // Byte writer model: ack ack_dly cycles after each wr_new.
   initial begin
      bus.wr_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.wr_new && ack_en) begin
            repeat (ack_dly) @(posedge clk);
            #1 bus.wr_done = 1'b1;
            @(posedge clk);
            #1 bus.wr_done = 1'b0;
         end
      end
   end

   initial begin
      exp_t       e;
      logic [2:0] ev;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.wr_new) begin
            new_cyc = cyc;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL stray wr_new: got %0h, expected none",
                        bus.wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_data", bus.wr_data, e.b);
               chk("grant", bus.grant, e.g);
            end
         end
         if (bus.done != 2'b00 || bus.err) begin
            if (bus.err) err_cyc = cyc;
            if (ev_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL stray event: got err=%0b done=%0b, expected none",
                        bus.err, bus.done);
            end else begin
               ev = ev_q.pop_front();
               chk("err/done", {bus.err, bus.done}, ev);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.len0 = '0;
      bus.len1 = '0;
      for (int i = 0; i < 32; i++) begin
         mem0[i] = 8'h00;
         mem1[i] = 8'h00;
      end

      repeat (3) @(negedge clk);
      chk("rst grant", bus.grant, 2'b00);
      chk("rst busy", bus.busy, 1'b0);
      chk("rst wr_new", bus.wr_new, 1'b0);
      chk("rst wr_data", bus.wr_data, 8'h00);
      chk("rst rd_addr", bus.rd_addr, 5'd0);
      chk("rst done", bus.done, 2'b00);
      chk("rst err", bus.err, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // req0, two payload bytes, slow writer
      ack_dly = 3;
      mem0[0] = 8'h11;
      mem0[1] = 8'h22;
      bus.len0 = 5'd2;
      pb(8'hA5, 2'b01); pb(8'h02, 2'b01); pb(8'h11, 2'b01);
      pb(8'h22, 2'b01); pb(8'h35, 2'b01);
      ev_q.push_back(3'b001);
      bus.req0 = 1'b1;
      wait_ev("t1 frame");
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("t1 busy after done", bus.busy, 1'b0);
      chk("t1 grant after done", bus.grant, 2'b00);
      repeat (5) @(negedge clk);
      chk("t1 drained", exp_q.size(), 0);

      // req1, empty payload
      ack_dly = 2;
      bus.len1 = 5'd0;
      pb(8'hA5, 2'b10); pb(8'h80, 2'b10); pb(8'h80, 2'b10);
      ev_q.push_back(3'b010);
      bus.req1 = 1'b1;
      wait_ev("t2 frame");
      bus.req1 = 1'b0;
      repeat (5) @(negedge clk);
      chk("t2 drained", exp_q.size(), 0);

      // both requesting from reset: round robin, one idle cycle between
      reset = 1'b1;
      ack_dly = 1;
      bus.len0 = 5'd1;
      bus.len1 = 5'd1;
      mem0[0] = 8'h10;
      mem1[0] = 8'h20;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      for (int f = 0; f < 2; f++) begin
         pb(8'hA5, 2'b01); pb(8'h01, 2'b01); pb(8'h10, 2'b01);
         pb(8'h11, 2'b01);
         ev_q.push_back(3'b001);
         pb(8'hA5, 2'b10); pb(8'h81, 2'b10); pb(8'h20, 2'b10);
         pb(8'hA1, 2'b10);
         ev_q.push_back(3'b010);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int f = 0; f < 4; f++) begin
         wait_ev("t3 frame");
         if (f == 3) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end else begin
            @(negedge clk);
            chk("t3 idle gap busy", bus.busy, 1'b0);
            @(negedge clk);
            chk("t3 next wr_new", bus.wr_new, 1'b1);
         end
      end
      repeat (5) @(negedge clk);
      chk("t3 drained", exp_q.size(), 0);

      // checksum wrap-around
      ack_dly = 2;
      bus.len0 = 5'd3;
      mem0[0] = 8'hFF;
      mem0[1] = 8'hFF;
      mem0[2] = 8'hFF;
      pb(8'hA5, 2'b01); pb(8'h03, 2'b01); pb(8'hFF, 2'b01);
      pb(8'hFF, 2'b01); pb(8'hFF, 2'b01); pb(8'h00, 2'b01);
      ev_q.push_back(3'b001);
      bus.req0 = 1'b1;
      wait_ev("t4 frame");
      bus.req0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("t4 drained", exp_q.size(), 0);

      // stalled writer: timeout abort
      ack_en = 1'b0;
      bus.len0 = 5'd2;
      pb(8'hA5, 2'b01);
      ev_q.push_back(3'b100);
      bus.req0 = 1'b1;
      wait_ev("t5 err");
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("t5 err latency", err_cyc - new_cyc, 8);
      chk("t5 grant after err", bus.grant, 2'b00);
      chk("t5 busy after err", bus.busy, 1'b0);
      repeat (12) @(negedge clk);
      chk("t5 drained", exp_q.size(), 0);
      ack_en = 1'b1;

      // reset mid-payload, then restart
      ack_dly = 1;
      bus.len0 = 5'd4;
      mem0[0] = 8'h01;
      mem0[1] = 8'h02;
      mem0[2] = 8'h03;
      mem0[3] = 8'h04;
      pb(8'hA5, 2'b01); pb(8'h04, 2'b01); pb(8'h01, 2'b01);
      pb(8'h02, 2'b01);
      bus.req0 = 1'b1;
      begin
         int k;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!(bus.wr_new && bus.wr_data == 8'h02) && k < 200);
         if (!(bus.wr_new && bus.wr_data == 8'h02)) begin
            tests++;
            fails++;
            $display("FAIL t6 pay byte: not seen within 200 cycles");
         end
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6 grant after rst", bus.grant, 2'b00);
      chk("t6 busy after rst", bus.busy, 1'b0);
      chk("t6 wr_new after rst", bus.wr_new, 1'b0);
      chk("t6 partial drained", exp_q.size(), 0);
      pb(8'hA5, 2'b01); pb(8'h04, 2'b01); pb(8'h01, 2'b01);
      pb(8'h02, 2'b01); pb(8'h03, 2'b01); pb(8'h04, 2'b01);
      pb(8'h0E, 2'b01);
      ev_q.push_back(3'b001);
      wait_ev("t6 restart");
      bus.req0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6 drained", exp_q.size(), 0);
      chk("events drained", ev_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
- Shares the single USB FIFO byte-writer path between two requesters (e.g. board-state sender and debug/status sender).
- Grants one requester at a time using round-robin and frames its message.
- Frame format: SYNC byte, header byte, 0..31 payload bytes, then an 8-bit checksum.
- Issues one byte at a time to the byte writer and waits for its completion pulse before issuing the next. Aborts the frame with an error if the writer stalls.

Parameters:
- SYNC_BYTE, 8'hA5: first byte of every frame.
- TIMEOUT, 1000: maximum cycles to wait for wr_done per byte, 1..65535. Counter is 16 bits.

Ports:
- clk  in  1: system clock. Single clock domain.
- reset  in  1: synchronous, active-high reset.
- req0  in  1: requester 0 has a frame pending. Level signal.
- len0  in  5: requester 0 payload length, 0..31.
- rdata0  in  8: requester 0 payload byte at rd_addr. Combinational from requester.
- req1  in  1: requester 1 pending.
- len1  in  5: requester 1 payload length.
- rdata1  in  8: requester 1 payload byte at rd_addr.
- rd_addr  out  5: payload byte index for the granted requester.
- grant  out  2: one-hot grant. Held for the whole frame.
- done  out  2: one-cycle pulse on the granted bit when the checksum byte completes.
- wr_data  out  8: byte to the writer. Valid while wr_new=1.
- wr_new  out  1: one-cycle pulse requesting the writer to send wr_data.
- wr_done  in  1: writer completion pulse. One cycle.
- busy  out  1: high whenever state is not IDLE.
- err  out  1: one-cycle pulse on timeout abort.

Behaviour:
- Reset values: grant=0, done=0, wr_new=0, wr_data=0, rd_addr=0, busy=0, err=0, state=IDLE, last=1 (so req0 wins the first tie), checksum=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT. A phase register selects SYNC, HDR, PAY, or SUM.
- IDLE:
  - If exactly one req is high, select it.
  - If both are high, select the requester not equal to last.
  - On the next cycle: grant is set, the selected len is latched, rd_addr=0, checksum=0, phase=SYNC, state=ISSUE.
- ISSUE (exactly one cycle):
  - wr_new=1, and wr_data is chosen by phase:
    - SYNC: SYNC_BYTE.
    - HDR: {src, 2'b00, len}.
    - PAY: rdata of the granted requester at rd_addr, sampled this cycle.
    - SUM: checksum.
  - Then clear the counter and go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On wr_done:
    - HDR or PAY: checksum += byte, mod 256.
    - Advance the phase:
      - SYNC → HDR.
      - HDR → PAY, or → SUM if len=0.
      - PAY → increment rd_addr; → SUM after byte len-1.
      - SUM → pulse done[src], set last=src, clear grant, go to IDLE.
    - Otherwise go to ISSUE on the next cycle.
  - If the counter reaches TIMEOUT without wr_done: pulse err, clear grant, set last=src, go to IDLE. No done pulse.
- Checksum covers the header and payload only, not SYNC. It is an 8-bit wrap-around sum.
- wr_done is ignored in IDLE and ISSUE.
- wr_done in the same cycle the counter reaches TIMEOUT: treated as success, no err.
- Minimum gap between wr_new pulses is 2 cycles (ISSUE, WAIT, then ISSUE).
- len and src are latched at grant; changes to len or req afterwards are ignored.
- Requester data contract:
  - A requester must hold its data stable until its done or err.
  - Dropping req mid-frame does not abort the frame.
- A new grant is evaluated only in IDLE. It is earliest the cycle after done/err, so there is 1 idle cycle between frames.
- Reset mid-frame: all outputs return to reset values on the next edge. No further wr_new is issued. The partial frame is abandoned.

Test Plan:
- req0, len0=2, rdata0 = {0x11, 0x22}; writer model acks 3 cycles after each wr_new.
  - Required: wr_data sequence A5, 02, 11, 22, 35.
  - Required: done=01 pulse once; grant=01 throughout; busy falls after done.
- req1 only, len1=0.
  - Required: bytes A5, 80, 80; done=10.
- req0 and req1 both held high from reset, each len=1, writer acks in 1 cycle.
  - Required frames in order: req0, req1, req0, req1 (round-robin).
  - Required: exactly 1 idle cycle between frames.
- req0 len=3 with payload FF, FF, FF.
  - Required: checksum byte 00 (03 + 3×FF = 0x300, mod 256).
- TIMEOUT=8; writer never asserts wr_done.
  - Required: one wr_new (A5), err pulse 8 cycles after entering WAIT, grant=00, no done, no further wr_new.
- Assert reset for 1 cycle during the PAY phase of a len=4 frame.
  - Required: the next cycle shows grant=0, busy=0, wr_new=0.
  - Required: with req0 still high, the frame restarts from A5.
